// File: rtl/calc_pkg.sv
// calc_pkg: shared operation codes, key classes, scan FSM states and the keypad map
package calc_pkg;
  localparam logic [1:0] OP_NONE = 2'd0;
  localparam logic [1:0] OP_SUMA = 2'd1;
  localparam logic [1:0] OP_RESTA = 2'd2;
  localparam logic [1:0] OP_IGUAL = 2'd3;
  typedef enum logic [2:0] {K_DIGITO, K_OPER, K_IGUAL, K_BORRAR, K_NULA} clase_t;
  typedef enum logic [1:0] {SCAN, DEBOUNCE, EMIT, WAIT_RELEASE} estado_t;
  typedef struct packed {
    clase_t clase;
    logic [3:0] valor;
  } tecla_t;
  // indexed by {row, column}; operator entries carry their OP_* code in valor
  localparam tecla_t MAPA [16] = '{
    '{K_DIGITO, 4'd1}, '{K_DIGITO, 4'd2}, '{K_DIGITO, 4'd3}, '{K_OPER, {2'b00, OP_SUMA}},
    '{K_DIGITO, 4'd4}, '{K_DIGITO, 4'd5}, '{K_DIGITO, 4'd6}, '{K_OPER, {2'b00, OP_RESTA}},
    '{K_DIGITO, 4'd7}, '{K_DIGITO, 4'd8}, '{K_DIGITO, 4'd9}, '{K_IGUAL, {2'b00, OP_IGUAL}},
    '{K_BORRAR, 4'd0}, '{K_DIGITO, 4'd0}, '{K_NULA, 4'd0}, '{K_NULA, 4'd0}
  };
endpackage

// File: rtl/contador_antirrebote.sv
// contador_antirrebote: saturating stability counter, stable_done after DEBOUNCE_CYC uncleared cycles
module contador_antirrebote #(
  parameter int DEBOUNCE_CYC = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic stable_done
);
  localparam int W = $clog2(DEBOUNCE_CYC + 1);
  logic [W-1:0] cnt;
  // count stable cycles, saturating at DEBOUNCE_CYC
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt <= '0;
    else cnt <= clear ? '0 : cnt + W'(cnt != W'(DEBOUNCE_CYC));
  assign stable_done = cnt == W'(DEBOUNCE_CYC);
endmodule

// File: rtl/teclado_calculadora.sv
// teclado_calculadora: 4x4 keypad scanner/debouncer/classifier; KEY_REPEAT_EN enables digit auto-repeat
module teclado_calculadora
  import calc_pkg::*;
#(
  parameter int SCAN_DIV = 16,
  parameter int DEBOUNCE_CYC = 1000,
  parameter int REPEAT_CYC = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] fila,
  output logic [3:0] columna,
  input  logic       ingresar_numero_1_en,
  input  logic       ingresar_numero_2_en,
  output logic [3:0] digito,
  output logic       digito_en,
  output logic       operando_en,
  output logic [1:0] que_operacion,
  output logic       igual_en,
  output logic       borrar_en
);
  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int REP_W = $clog2(REPEAT_CYC + 1);
  estado_t estado, estado_sig;
  logic [1:0] col, fila_idx;
  logic [3:0] fila_lat, objetivo;
  logic [DIV_W-1:0] div_cnt;
  logic fin_div, listo, limpiar, multiple, repetir, emit, compuerta;
  tecla_t tecla;
  assign columna = ~(4'b0001 << col);
  assign fin_div = div_cnt == DIV_W'(SCAN_DIV - 1);
  assign multiple = $countones(~fila_lat) > 1;
  assign compuerta = ingresar_numero_1_en | ingresar_numero_2_en;
  assign emit = estado_sig == EMIT;
  assign objetivo = estado == WAIT_RELEASE ? 4'hF : fila_lat;
  assign limpiar = estado == SCAN || estado_sig != estado || fila != objetivo;
  contador_antirrebote #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_antirrebote (
    .clk(clk), .reset(reset), .clear(limpiar), .stable_done(listo)
  );
  // decode the latched row and frozen column into a key, then pick the next scan state
  always_comb begin
    fila_idx = !fila_lat[0] ? 2'd0 : !fila_lat[1] ? 2'd1 : !fila_lat[2] ? 2'd2 : 2'd3;
    tecla = MAPA[{fila_idx, col}];
    estado_sig = estado == SCAN ? ((fin_div && fila != 4'hF) ? DEBOUNCE : SCAN) :
                 estado == DEBOUNCE ? ((fila != fila_lat) ? SCAN : listo ? (multiple ? WAIT_RELEASE : EMIT) : DEBOUNCE) :
                 estado == EMIT ? WAIT_RELEASE :
                 listo ? SCAN : repetir ? EMIT : WAIT_RELEASE;
  end
`ifdef KEY_REPEAT_EN
  logic [REP_W-1:0] rep_cnt;
  logic sostenida;
  assign sostenida = estado == WAIT_RELEASE && fila == fila_lat;
  assign repetir = sostenida && rep_cnt == REP_W'(REPEAT_CYC - 1) && tecla.clase == K_DIGITO && !multiple;
  // cycles since the last emit while the same digit stays held
  always_ff @(posedge clk or negedge reset)
    if (!reset) rep_cnt <= '0;
    else rep_cnt <= estado == EMIT ? REP_W'(1) : !sostenida ? '0 : rep_cnt + REP_W'(rep_cnt != REP_W'(REPEAT_CYC));
`else
  assign repetir = REP_W == 0;
`endif
  // scan state, column rotation, key latch and registered strobes for the EMIT cycle
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      estado <= SCAN;
      col <= 2'd0;
      div_cnt <= '0;
      fila_lat <= 4'hF;
      digito <= 4'd0;
      que_operacion <= OP_NONE;
      digito_en <= 1'b0;
      operando_en <= 1'b0;
      igual_en <= 1'b0;
      borrar_en <= 1'b0;
    end else begin
      estado <= estado_sig;
      div_cnt <= (estado == SCAN && !fin_div) ? div_cnt + DIV_W'(1) : '0;
      col <= ((estado != SCAN && estado_sig == SCAN) || (estado == SCAN && fin_div && fila == 4'hF)) ? col + 2'd1 : col;
      fila_lat <= (estado == SCAN && estado_sig == DEBOUNCE) ? fila : fila_lat;
      digito_en <= emit && tecla.clase == K_DIGITO && compuerta;
      operando_en <= emit && (tecla.clase == K_OPER || tecla.clase == K_IGUAL);
      igual_en <= emit && tecla.clase == K_IGUAL;
      borrar_en <= emit && tecla.clase == K_BORRAR;
      digito <= (emit && tecla.clase == K_DIGITO && compuerta) ? tecla.valor : digito;
      que_operacion <= (emit && (tecla.clase == K_OPER || tecla.clase == K_IGUAL)) ? tecla.valor[1:0] :
                       (emit && tecla.clase == K_BORRAR) ? OP_NONE : que_operacion;
    end
endmodule
